// File: rtl/game_pkg.sv
// Shared game-flow types and playfield geometry constants.
// Used by the game controller, its score counter and the playfield renderer.
// Geometry constants are sized to the 11-bit tube x-position bus.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } game_state_t;

    localparam int NUM_TUBES = 3;
    localparam int X_W       = 11;
    localparam int SCORE_W   = 10;

    // Bird left edge; also the line a tube's right edge must reach to score.
    localparam logic [X_W-1:0] BIRD_X     = 11'd200;
    localparam logic [X_W-1:0] TUBE_WIDTH = 11'd120;
    // Tube x positions at or beyond this are off-screen / inactive.
    localparam logic [X_W-1:0] H_ACTIVE   = 11'd1024;

endpackage

// File: rtl/game_ctrl_score_counter.sv
// Score counter: per-tube passed flags, cleared-tube adder, saturating score, best score.
// Latency: score/score_pulse update the cycle after a scoring frame; best the cycle after a crash.
// Backpressure: none; enables come from the game-flow controller.
// Ports: clear (new game), score_en (scoring frame in PLAY), latch_best (crash),
//        tube_x (tube left edges), score/best (binary), score_pulse (one cycle per increment).
module score_counter
    import game_pkg::*;
#(
    parameter int SCORE_MAX = 999
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             score_en,
    input  logic                             latch_best,
    input  logic [NUM_TUBES-1:0][X_W-1:0]    tube_x,
    output logic [SCORE_W-1:0]               score,
    output logic [SCORE_W-1:0]               best,
    output logic                             score_pulse
);

    localparam logic [11:0] SAT = 12'(SCORE_MAX);

    logic [NUM_TUBES-1:0] passed;
    logic [NUM_TUBES-1:0] passed_nxt;
    logic [1:0]           n_cleared;
    logic [11:0]          right_edge [NUM_TUBES];
    logic [11:0]          sum;
    logic [SCORE_W-1:0]   score_sat;

    always_comb begin
        passed_nxt = passed;
        n_cleared  = '0;
        for (int i = 0; i < NUM_TUBES; i++) begin
            // 12-bit right edge so a tube near x=2047 cannot wrap below BIRD_X.
            right_edge[i] = {1'b0, tube_x[i]} + {1'b0, TUBE_WIDTH};
            if (right_edge[i] <= {1'b0, BIRD_X} && tube_x[i] < H_ACTIVE && !passed[i]) begin
                passed_nxt[i] = 1'b1;
                n_cleared     = n_cleared + 2'd1;
            end
            // A tube back at/right of the bird, or parked off-screen, has respawned.
            if (tube_x[i] >= BIRD_X || tube_x[i] >= H_ACTIVE) begin
                passed_nxt[i] = 1'b0;
            end
        end
        sum       = {2'b00, score} + {10'd0, n_cleared};
        score_sat = (sum > SAT) ? SAT[SCORE_W-1:0] : sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            passed      <= '0;
            score       <= '0;
            best        <= '0;
            score_pulse <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            if (clear) begin
                passed <= '0;
                score  <= '0;
            end else if (score_en) begin
                passed      <= passed_nxt;
                score       <= score_sat;
                // Pulse even when saturated so the HUD still sees the event.
                score_pulse <= (n_cleared != 2'd0);
            end
            if (latch_best && score > best) begin
                best <= score;
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE -> PLAY -> DEAD -> IDLE, owns playfield reset/freeze and jump gating.
// Latency: state, game_rst, freeze, score outputs registered (1 cycle); mouse_left_game combinational.
// Backpressure: none; DEAD ignores clicks until DEAD_FRAMES frame ticks have elapsed.
// Ports: clk, rst_n, frame_tick, mouse_left, collision, tube_x in;
//        game_rst, freeze, mouse_left_game, state, score, best, score_pulse out.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DEAD_FRAMES = 60,
    parameter int SCORE_MAX   = 999
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             frame_tick,
    input  logic                             mouse_left,
    input  logic                             collision,
    input  logic [NUM_TUBES-1:0][X_W-1:0]    tube_x,
    output logic                             game_rst,
    output logic                             freeze,
    output logic                             mouse_left_game,
    output logic [1:0]                       state,
    output logic [SCORE_W-1:0]               score,
    output logic [SCORE_W-1:0]               best,
    output logic                             score_pulse
);

    localparam int              CNT_W    = $clog2(DEAD_FRAMES + 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_FRAMES);

    game_state_t      state_q;
    game_state_t      state_nxt;
    logic             mouse_q;
    logic             click;
    logic [CNT_W-1:0] dead_cnt;

    assign click = mouse_left & ~mouse_q;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (click) state_nxt = PLAY;
            PLAY: if (collision) state_nxt = DEAD;
            // Compares the registered count, so a click on the tick that
            // reaches the limit is still discarded.
            DEAD: if (click && dead_cnt == DEAD_LIM) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            game_rst <= 1'b1;
            freeze   <= 1'b0;
            mouse_q  <= 1'b0;
            dead_cnt <= '0;
        end else begin
            state_q  <= state_nxt;
            // Decoded from next state so they line up with the state output.
            game_rst <= (state_nxt == IDLE);
            freeze   <= (state_nxt == DEAD);
            mouse_q  <= mouse_left;
            if (state_q == PLAY && collision) begin
                dead_cnt <= '0;
            end else if (state_q == DEAD && frame_tick && dead_cnt < DEAD_LIM) begin
                dead_cnt <= dead_cnt + CNT_W'(1);
            end
        end
    end

    assign state           = state_q;
    assign mouse_left_game = mouse_left & (state_q == PLAY);

    // Collision beats a scoring tick: no increment, best sees the pre-tick score.
    score_counter #(
        .SCORE_MAX (SCORE_MAX)
    ) u_score (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (state_q == IDLE && click),
        .score_en    (state_q == PLAY && frame_tick && !collision),
        .latch_best  (state_q == PLAY && collision),
        .tube_x      (tube_x),
        .score       (score),
        .best        (best),
        .score_pulse (score_pulse)
    );

endmodule
